// File: rtl/decode_stage_if.sv
// Fetch <-> decode link: fetch's pipeline register, redirect controls and the decode bundle.
interface decode_stage_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 16
);
    logic [INSTR_W-1:0] instruction_r;
    logic [ADDR_W-1:0]  pc_plus_one_r;
    logic               flush;
    logic               pc_write;
    logic [ADDR_W-1:0]  pc_write_back_value;
    logic               clear_instruction;
    logic               dec_valid;
    logic [4:0]         dec_opcode;
    logic [2:0]         dec_rd;
    logic [2:0]         dec_rs1;
    logic [2:0]         dec_rs2;
    logic               dec_has_imm;
    logic [ADDR_W-1:0]  dec_imm;
    logic [ADDR_W-1:0]  dec_pc_plus_one;

    modport master (
        output instruction_r, pc_plus_one_r, flush,
        input  pc_write, pc_write_back_value, clear_instruction,
        input  dec_valid, dec_opcode, dec_rd, dec_rs1, dec_rs2, dec_has_imm, dec_imm,
        input  dec_pc_plus_one
    );

    modport slave (
        input  instruction_r, pc_plus_one_r, flush,
        output pc_write, pc_write_back_value, clear_instruction,
        output dec_valid, dec_opcode, dec_rd, dec_rs1, dec_rs2, dec_has_imm, dec_imm,
        output dec_pc_plus_one
    );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: turns 16-bit fetch words into a registered decode bundle, reassembling
// opcode+immediate pairs and redirecting fetch on an immediate jump.
module decode_stage #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned INSTR_W  = 16,
    parameter bit          SIGN_EXT = 1'b0
) (
    input logic           clk,
    input logic           reset,
    decode_stage_if.slave bus
);
    localparam int unsigned ExtW = ADDR_W - INSTR_W;

    localparam logic [4:0] OpNop  = 5'b00000;
    localparam logic [4:0] OpLdm  = 5'b10000;
    localparam logic [4:0] OpIadd = 5'b10001;
    localparam logic [4:0] OpLdd  = 5'b10010;
    localparam logic [4:0] OpStd  = 5'b10011;
    localparam logic [4:0] OpJmpi = 5'b11001;

    typedef enum logic [0:0] {StExpectOp, StExpectImm} state_e;

    typedef struct packed {
        logic [4:0]        op;
        logic [2:0]        rd;
        logic [2:0]        rs1;
        logic [2:0]        rs2;
        logic [ADDR_W-1:0] pc;
    } latch_t;

    typedef struct packed {
        logic              valid;
        logic [4:0]        op;
        logic [2:0]        rd;
        logic [2:0]        rs1;
        logic [2:0]        rs2;
        logic              has_imm;
        logic [ADDR_W-1:0] imm;
        logic [ADDR_W-1:0] pc;
    } bundle_t;

    state_e  state_q, state_d;
    latch_t  lat_q, lat_d;
    bundle_t bundle_q, bundle_d;

    logic [4:0]        word_op;
    logic [2:0]        word_rd, word_rs1, word_rs2;
    logic [ADDR_W-1:0] word_ext;
    logic              word_two;

    assign word_op  = bus.instruction_r[INSTR_W-1 -: 5];
    assign word_rd  = bus.instruction_r[INSTR_W-6 -: 3];
    assign word_rs1 = bus.instruction_r[INSTR_W-9 -: 3];
    assign word_rs2 = bus.instruction_r[INSTR_W-12 -: 3];
    assign word_ext = SIGN_EXT ? {{ExtW{bus.instruction_r[INSTR_W-1]}}, bus.instruction_r}
                               : {{ExtW{1'b0}}, bus.instruction_r};
    assign word_two = (word_op == OpLdm) || (word_op == OpIadd) || (word_op == OpLdd) ||
                      (word_op == OpStd) || (word_op == OpJmpi);

    always_comb begin
        state_d                 = state_q;
        lat_d                   = lat_q;
        bundle_d                = '0;
        bus.pc_write            = 1'b0;
        bus.clear_instruction   = 1'b0;
        bus.pc_write_back_value = '0;
        if (bus.flush) begin
            state_d = StExpectOp;
            lat_d   = '0;
        end else begin
            unique case (state_q)
                StExpectOp: begin
                    if (word_two) begin
                        lat_d   = '{op: word_op, rd: word_rd, rs1: word_rs1, rs2: word_rs2,
                                    pc: bus.pc_plus_one_r};
                        state_d = StExpectImm;
                    end else if (word_op != OpNop) begin
                        bundle_d = '{valid: 1'b1, op: word_op, rd: word_rd, rs1: word_rs1,
                                     rs2: word_rs2, has_imm: 1'b0, imm: '0,
                                     pc: bus.pc_plus_one_r};
                    end
                end
                StExpectImm: begin
                    // The word here is always the immediate, whatever its top bits say.
                    bundle_d = '{valid: 1'b1, op: lat_q.op, rd: lat_q.rd, rs1: lat_q.rs1,
                                 rs2: lat_q.rs2, has_imm: 1'b1, imm: word_ext, pc: lat_q.pc};
                    state_d  = StExpectOp;
                    if (lat_q.op == OpJmpi && !reset) begin
                        bus.pc_write            = 1'b1;
                        bus.clear_instruction   = 1'b1;
                        bus.pc_write_back_value = word_ext;
                    end
                end
                default: state_d = StExpectOp;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StExpectOp;
            lat_q    <= '0;
            bundle_q <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            bundle_q <= bundle_d;
        end
    end

    assign bus.dec_valid       = bundle_q.valid;
    assign bus.dec_opcode      = bundle_q.op;
    assign bus.dec_rd          = bundle_q.rd;
    assign bus.dec_rs1         = bundle_q.rs1;
    assign bus.dec_rs2         = bundle_q.rs2;
    assign bus.dec_has_imm     = bundle_q.has_imm;
    assign bus.dec_imm         = bundle_q.imm;
    assign bus.dec_pc_plus_one = bundle_q.pc;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: zero- and sign-extending instances share stimulus and are
// compared against an instruction-level model of the decode rules.
module tb_decode_stage;
    localparam int unsigned AW = 32;
    localparam int unsigned IW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    decode_stage_if #(.ADDR_W(AW), .INSTR_W(IW)) bus0 ();
    decode_stage_if #(.ADDR_W(AW), .INSTR_W(IW)) bus1 ();

    decode_stage #(.ADDR_W(AW), .INSTR_W(IW), .SIGN_EXT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    decode_stage #(.ADDR_W(AW), .INSTR_W(IW), .SIGN_EXT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: an opcode word waiting for its immediate, plus the expected outputs.
    bit          pending = 1'b0;
    logic [15:0] pend_word = '0;
    logic [31:0] pend_pc = '0;
    logic [15:0] cur_word;
    logic [31:0] cur_pc;
    logic        cur_fl, cur_rst;
    logic [79:0] exp_b0 = '0, exp_b1 = '0;
    logic [33:0] exp_c0 = '0, exp_c1 = '0;

    function automatic logic [31:0] ext(input logic [15:0] w, input bit s);
        return s ? {{16{w[15]}}, w} : {16'h0, w};
    endfunction

    function automatic bit two_word(input logic [4:0] op);
        return op inside {5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b11001};
    endfunction

    function automatic logic [15:0] rand_word();
        logic [4:0] ops [5] = '{5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b11001};
        logic [15:0] w = 16'($urandom);
        int unsigned r = $urandom_range(0, 5);
        if (r < 2) w[15:11] = ops[$urandom_range(0, 4)];
        else if (r == 2) w = 16'h0000;
        return w;
    endfunction

    function automatic logic [79:0] bun0();
        return {bus0.dec_valid, bus0.dec_opcode, bus0.dec_rd, bus0.dec_rs1, bus0.dec_rs2,
                bus0.dec_has_imm, bus0.dec_imm, bus0.dec_pc_plus_one};
    endfunction
    function automatic logic [79:0] bun1();
        return {bus1.dec_valid, bus1.dec_opcode, bus1.dec_rd, bus1.dec_rs1, bus1.dec_rs2,
                bus1.dec_has_imm, bus1.dec_imm, bus1.dec_pc_plus_one};
    endfunction
    function automatic logic [33:0] ctl0();
        return {bus0.pc_write, bus0.clear_instruction, bus0.pc_write_back_value};
    endfunction
    function automatic logic [33:0] ctl1();
        return {bus1.pc_write, bus1.clear_instruction, bus1.pc_write_back_value};
    endfunction

    // Apply one cycle of inputs mid-cycle and derive the expected fetch controls.
    task automatic drive(input logic [15:0] w, input logic [31:0] pc, input logic fl,
                         input logic rst);
        bit jmp;
        @(negedge clk);
        bus0.instruction_r = w;  bus1.instruction_r = w;
        bus0.pc_plus_one_r = pc; bus1.pc_plus_one_r = pc;
        bus0.flush = fl;         bus1.flush = fl;
        reset = rst;
        cur_word = w; cur_pc = pc; cur_fl = fl; cur_rst = rst;
        jmp = !rst && !fl && pending && (pend_word[15:11] == 5'b11001);
        exp_c0 = {jmp, jmp, jmp ? ext(w, 1'b0) : 32'h0};
        exp_c1 = {jmp, jmp, jmp ? ext(w, 1'b1) : 32'h0};
        #1;
    endtask

    // Advance the model across the rising edge.
    task automatic clock_edge();
        @(posedge clk);
        if (cur_rst || cur_fl) begin
            pending = 1'b0; exp_b0 = '0; exp_b1 = '0;
        end else if (pending) begin
            exp_b0  = {1'b1, pend_word[15:2], 1'b1, ext(cur_word, 1'b0), pend_pc};
            exp_b1  = {1'b1, pend_word[15:2], 1'b1, ext(cur_word, 1'b1), pend_pc};
            pending = 1'b0;
        end else if (two_word(cur_word[15:11])) begin
            pending = 1'b1; pend_word = cur_word; pend_pc = cur_pc;
            exp_b0  = '0; exp_b1 = '0;
        end else if (cur_word[15:11] == 5'd0) begin
            exp_b0 = '0; exp_b1 = '0;
        end else begin
            exp_b0 = {1'b1, cur_word[15:2], 1'b0, 32'h0, cur_pc};
            exp_b1 = exp_b0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            drive((i == 0) ? 16'h8300 : 16'h0000, 32'(i), 1'b0, i < 2);
            n_cmp++;
            if ({ctl0(), ctl1()} !== {exp_c0, exp_c1}) begin
                n_err++; $display("FAIL reset_ctl[%0d]: got %h want %h", i, {ctl0(), ctl1()},
                                  {exp_c0, exp_c1});
            end
            clock_edge();
            n_cmp++;
            if ({bun0(), bun1(), ctl0()} !== '0) begin
                n_err++; $display("FAIL reset_zero[%0d]: got %h want 0", i, {bun0(), bun1()});
            end
        end
    endtask

    task automatic test_one_word();
        logic [15:0] w;
        drive(16'h0AE4, 32'h21, 1'b0, 1'b0);
        clock_edge();
        n_cmp++;
        if ({bus0.dec_valid, bus0.dec_opcode, bus0.dec_rd, bus0.dec_rs1, bus0.dec_rs2,
             bus0.dec_has_imm, bus0.dec_imm, bus0.dec_pc_plus_one} !==
            {1'b1, 5'd1, 3'd2, 3'd7, 3'd1, 1'b0, 32'h0, 32'h21}) begin
            n_err++; $display("FAIL one_word_0AE4: got %h want valid op1 rd2 rs7 rs1 pc21", bun0());
        end
        for (int i = 0; i < 20; i++) begin
            w = rand_word();
            while (two_word(w[15:11])) w = rand_word();
            drive(w, $urandom, 1'b0, 1'b0);
            clock_edge();
            n_cmp++;
            if ({bun0(), bun1()} !== {exp_b0, exp_b1}) begin
                n_err++; $display("FAIL one_word_rand[%0d]: got %h want %h", i, bun0(), exp_b0);
            end
        end
    endtask

    task automatic test_two_word();
        drive(16'h8300, 32'h50, 1'b0, 1'b0);
        clock_edge();
        n_cmp++;
        if (bus0.dec_valid !== 1'b0 || bus1.dec_valid !== 1'b0) begin
            n_err++; $display("FAIL ldm_op_cycle: got valid %b want 0", bus0.dec_valid);
        end
        drive(16'hFFFE, 32'h51, 1'b0, 1'b0);
        clock_edge();
        n_cmp++;
        if ({bus0.dec_valid, bus0.dec_opcode, bus0.dec_rd, bus0.dec_has_imm, bus0.dec_imm,
             bus1.dec_imm, bus0.dec_pc_plus_one} !==
            {1'b1, 5'b10000, 3'd3, 1'b1, 32'h0000FFFE, 32'hFFFFFFFE, 32'h50}) begin
            n_err++; $display("FAIL ldm_imm: got imm0 %h imm1 %h want 0000fffe fffffffe",
                              bus0.dec_imm, bus1.dec_imm);
        end
        // Back-to-back pairs: every word after an immediate is an opcode.
        for (int i = 0; i < 24; i++) begin
            logic [15:0] w = rand_word();
            if (i % 2 == 0) while (!two_word(w[15:11])) w = rand_word();
            drive(w, $urandom, 1'b0, 1'b0);
            n_cmp++;
            if ({ctl0(), ctl1()} !== {exp_c0, exp_c1}) begin
                n_err++; $display("FAIL b2b_ctl[%0d]: got %h want %h", i, ctl0(), exp_c0);
            end
            clock_edge();
            n_cmp++;
            if ({bun0(), bun1()} !== {exp_b0, exp_b1}) begin
                n_err++; $display("FAIL b2b_bundle[%0d]: got %h want %h", i, bun0(), exp_b0);
            end
        end
    endtask

    task automatic test_jmpi();
        drive(16'hC800, 32'h60, 1'b0, 1'b0);
        n_cmp++;
        if (bus0.pc_write !== 1'b0) begin
            n_err++; $display("FAIL jmpi_op_cycle: got pc_write %b want 0", bus0.pc_write);
        end
        clock_edge();
        drive(16'h0040, 32'h61, 1'b0, 1'b0);
        n_cmp++;
        if ({ctl0(), ctl1()} !== {1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h40}) begin
            n_err++; $display("FAIL jmpi_redirect: got %h want 3_00000040", ctl0());
        end
        clock_edge();
        drive(16'h0000, 32'h62, 1'b0, 1'b0);
        n_cmp++;
        if ({ctl0(), ctl1()} !== '0) begin
            n_err++; $display("FAIL jmpi_pulse_end: got %h want 0", ctl0());
        end
        clock_edge();
    endtask

    task automatic test_flush();
        drive(16'h8A40, 32'h70, 1'b0, 1'b0);
        clock_edge();
        drive(16'h1234, 32'h71, 1'b1, 1'b0);
        clock_edge();
        n_cmp++;
        if (bus0.dec_valid !== 1'b0 || bun1() !== exp_b1) begin
            n_err++; $display("FAIL flush_imm: got valid %b want 0", bus0.dec_valid);
        end
        drive(16'h0AE4, 32'h72, 1'b0, 1'b0);
        clock_edge();
        n_cmp++;
        if ({bus0.dec_valid, bus0.dec_opcode, bus0.dec_has_imm, bus0.dec_pc_plus_one} !==
            {1'b1, 5'd1, 1'b0, 32'h72}) begin
            n_err++; $display("FAIL flush_then_op: got %h want valid op1 pc72", bun0());
        end
        drive(16'hC800, 32'h73, 1'b0, 1'b0);
        clock_edge();
        drive(16'h0040, 32'h74, 1'b1, 1'b0);
        n_cmp++;
        if ({ctl0(), ctl1()} !== '0) begin
            n_err++; $display("FAIL flush_over_jmpi: got %h want 0", ctl0());
        end
        clock_edge();
    endtask

    task automatic test_reset_mid();
        drive(16'hC800, 32'h80, 1'b0, 1'b0);
        clock_edge();
        drive(16'h0040, 32'h81, 1'b0, 1'b1);
        n_cmp++;
        if ({ctl0(), ctl1()} !== '0) begin
            n_err++; $display("FAIL reset_mid_ctl: got %h want 0", ctl0());
        end
        clock_edge();
        n_cmp++;
        if ({bun0(), bun1()} !== '0) begin
            n_err++; $display("FAIL reset_mid_bundle: got %h want 0", bun0());
        end
        drive(16'h0AE4, 32'h82, 1'b0, 1'b0);
        clock_edge();
        n_cmp++;
        if (bun0() !== {1'b1, 14'h0AE4 >> 2, 1'b0, 32'h0, 32'h82}) begin
            n_err++; $display("FAIL reset_mid_next_op: got %h want %h", bun0(),
                              {1'b1, 14'h0AE4 >> 2, 1'b0, 32'h0, 32'h82});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(rand_word(), $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
            n_cmp++;
            if ({ctl0(), ctl1()} !== {exp_c0, exp_c1}) begin
                n_err++; $display("FAIL rand_ctl[%0d]: got %h want %h", i, {ctl0(), ctl1()},
                                  {exp_c0, exp_c1});
            end
            clock_edge();
            n_cmp++;
            if ({bun0(), bun1()} !== {exp_b0, exp_b1}) begin
                n_err++; $display("FAIL rand_bundle[%0d]: got %h want %h", i, {bun0(), bun1()},
                                  {exp_b0, exp_b1});
            end
        end
    endtask

    initial begin
        bus0.instruction_r = '0; bus1.instruction_r = '0;
        bus0.pc_plus_one_r = '0; bus1.pc_plus_one_r = '0;
        bus0.flush = 1'b0;       bus1.flush = 1'b0;
        test_reset();
        test_one_word();
        test_two_word();
        test_jmpi();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
